// File: rtl/axi_mch_burst_arbiter_pkg.sv
// Shared types and constants for the multi-channel AXI burst arbiter.
// The write and read FSM state enums live here alongside a constant-safe clog2.
package axi_mch_pkg;

    localparam int DEF_CH_NUM          = 4;
    localparam int DEF_CTRL_ADDR_WIDTH = 28;
    localparam int DEF_LEVEL_WIDTH     = 9;
    localparam int DEF_RFIFO_DEPTH     = 256;
    localparam int DEF_BRUST_LEN       = 8;
    localparam int DEF_ADDR_STEP       = 64;
    localparam int DEF_FRAME_BURSTS    = 1024;

    typedef enum logic [1:0] {W_IDLE, W_ARB, W_ADDR, W_DATA} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ARB, R_ADDR, R_DATA} r_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) r++;
        return r;
    endfunction

    // Index width that never collapses to zero for a single-channel build.
    function automatic int idx_w(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_mch_burst_arbiter_if.sv
// AXI address/handshake signals between the burst arbiter and the DDR controller.
interface axi_mch_burst_arbiter_if #(
    parameter int ADDR_W = 28
);
    logic [3:0]        M_AXI_AWID;
    logic [ADDR_W-1:0] M_AXI_AWADDR;
    logic              M_AXI_AWVALID;
    logic              M_AXI_AWREADY;
    logic              M_AXI_WREADY;
    logic              M_AXI_WLAST;
    logic [3:0]        M_AXI_ARID;
    logic [ADDR_W-1:0] M_AXI_ARADDR;
    logic              M_AXI_ARVALID;
    logic              M_AXI_ARREADY;
    logic              M_AXI_RVALID;
    logic              M_AXI_RLAST;

    modport master (
        output M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWVALID,
        input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_WLAST,
        output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARVALID,
        input  M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RLAST
    );

    modport slave (
        input  M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWVALID,
        output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_WLAST,
        input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARVALID,
        output M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RLAST
    );
endinterface

// File: rtl/axi_mch_burst_arbiter_rr_arbiter.sv
// Round-robin arbiter: search starts at the channel after the last accepted grant.
// The stored pointer is that start position, so after reset channel 0 has priority.
module rr_arbiter
    import axi_mch_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          accept,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);
    logic [IW-1:0] start_q;

    always_comb begin
        int p;
        p       = 0;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int i = 0; i < N; i++) begin
            p = int'(start_q) + i;
            if (p >= N) p = p - N;
            if (!any && req[p]) begin
                any     = 1'b1;
                gnt_idx = IW'(p);
                gnt[p]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            start_q <= '0;
        else if (accept && any)
            start_q <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end

endmodule

// File: rtl/axi_mch_burst_arbiter.sv
// Multi-channel AXI burst engine: round-robin write and read FSMs onto one AXI
// master, each channel owning a ring of FRAME_BURSTS bursts with frame tracking.
module axi_mch_burst_arbiter
    import axi_mch_pkg::*;
#(
    parameter  int CH_NUM          = DEF_CH_NUM,
    parameter  int CTRL_ADDR_WIDTH = DEF_CTRL_ADDR_WIDTH,
    parameter  int LEVEL_WIDTH     = DEF_LEVEL_WIDTH,
    parameter  int RFIFO_DEPTH     = DEF_RFIFO_DEPTH,
    parameter  int M_AXI_BRUST_LEN = DEF_BRUST_LEN,
    parameter  int ADDR_STEP       = DEF_ADDR_STEP,
    parameter  int FRAME_BURSTS    = DEF_FRAME_BURSTS,
    parameter  logic [CTRL_ADDR_WIDTH-1:0] CH_REGION = 28'h0100000,
    localparam int IW              = idx_w(CH_NUM)
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESET,
    input  logic                          DDR_INIT_DONE,
    axi_mch_burst_arbiter_if.master       m_axi,
    input  logic [CH_NUM*LEVEL_WIDTH-1:0] wfifo_rd_water_level,
    output logic [CH_NUM-1:0]             wfifo_rd_req,
    output logic [IW-1:0]                 wdata_sel,
    input  logic [CH_NUM*LEVEL_WIDTH-1:0] rfifo_wr_water_level,
    output logic [CH_NUM-1:0]             rfifo_wr_req,
    input  logic [CH_NUM-1:0]             ch_wr_en,
    input  logic [CH_NUM-1:0]             ch_rd_en,
    input  logic [CH_NUM-1:0]             ch_sync,
    output logic [CH_NUM-1:0]             wr_fram_done,
    output logic [CH_NUM-1:0]             rd_fram_done
);
    localparam int PTR_W = clog2(FRAME_BURSTS);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FRAME_BURSTS - 1);
    localparam logic [LEVEL_WIDTH-1:0] W_MIN = LEVEL_WIDTH'(M_AXI_BRUST_LEN);
    localparam logic [LEVEL_WIDTH-1:0] R_MAX = LEVEL_WIDTH'(RFIFO_DEPTH - M_AXI_BRUST_LEN);

    w_state_t w_state;
    r_state_t r_state;

    logic [IW-1:0]              wr_ch, rd_ch;
    logic                       awvalid_q, arvalid_q;
    logic [3:0]                 awid_q, arid_q;
    logic [CTRL_ADDR_WIDTH-1:0] awaddr_q, araddr_q;

    logic [PTR_W-1:0]  wr_ptr [CH_NUM];
    logic [PTR_W-1:0]  rd_ptr [CH_NUM];
    logic [CH_NUM-1:0] wr_pend, rd_pend, frame_valid;

    logic [CH_NUM-1:0] w_req, r_req, w_busy, r_busy, w_end, r_end;
    logic [CH_NUM-1:0] w_gnt, r_gnt;
    logic [IW-1:0]     w_gnt_idx, r_gnt_idx;
    logic              w_any, r_any;

    function automatic logic [CTRL_ADDR_WIDTH-1:0] burst_addr(input logic [IW-1:0] ch,
                                                              input logic [PTR_W-1:0] ptr);
        return CTRL_ADDR_WIDTH'(ch) * CH_REGION
             + CTRL_ADDR_WIDTH'(ptr) * CTRL_ADDR_WIDTH'(ADDR_STEP);
    endfunction

    assign m_axi.M_AXI_AWID    = awid_q;
    assign m_axi.M_AXI_AWADDR  = awaddr_q;
    assign m_axi.M_AXI_AWVALID = awvalid_q;
    assign m_axi.M_AXI_ARID    = arid_q;
    assign m_axi.M_AXI_ARADDR  = araddr_q;
    assign m_axi.M_AXI_ARVALID = arvalid_q;
    assign wdata_sel           = wr_ch;

    always_comb begin
        w_req        = '0;
        r_req        = '0;
        w_busy       = '0;
        r_busy       = '0;
        w_end        = '0;
        r_end        = '0;
        wfifo_rd_req = '0;
        rfifo_wr_req = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            w_req[c]  = DDR_INIT_DONE && ch_wr_en[c]
                     && (wfifo_rd_water_level[c*LEVEL_WIDTH +: LEVEL_WIDTH] >= W_MIN);
            r_req[c]  = DDR_INIT_DONE && ch_rd_en[c] && frame_valid[c]
                     && (rfifo_wr_water_level[c*LEVEL_WIDTH +: LEVEL_WIDTH] <= R_MAX);
            w_busy[c] = (w_state == W_ADDR || w_state == W_DATA) && wr_ch == IW'(c);
            r_busy[c] = (r_state == R_ADDR || r_state == R_DATA) && rd_ch == IW'(c);
            // FWFT write FIFO: the head word is on WDATA, pop as the controller takes it.
            wfifo_rd_req[c] = (w_state == W_DATA) && wr_ch == IW'(c) && m_axi.M_AXI_WREADY;
            rfifo_wr_req[c] = (r_state == R_DATA) && rd_ch == IW'(c) && m_axi.M_AXI_RVALID;
            w_end[c]  = wfifo_rd_req[c] && m_axi.M_AXI_WLAST;
            r_end[c]  = rfifo_wr_req[c] && m_axi.M_AXI_RLAST;
        end
    end

    rr_arbiter #(.N(CH_NUM)) u_w_arb (
        .clk     (M_AXI_ACLK),
        .rst     (M_AXI_ARESET),
        .req     (w_req),
        .accept  (w_state == W_ARB),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    rr_arbiter #(.N(CH_NUM)) u_r_arb (
        .clk     (M_AXI_ACLK),
        .rst     (M_AXI_ARESET),
        .req     (r_req),
        .accept  (r_state == R_ARB),
        .gnt     (r_gnt),
        .gnt_idx (r_gnt_idx),
        .any     (r_any)
    );

    // A sync landing on the grant cycle clears the pointer now, so issue slot 0.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            w_state   <= W_IDLE;
            wr_ch     <= '0;
            awvalid_q <= 1'b0;
            awid_q    <= '0;
            awaddr_q  <= '0;
        end else begin
            case (w_state)
                W_IDLE: if (DDR_INIT_DONE) w_state <= W_ARB;
                W_ARB: begin
                    if (w_any) begin
                        wr_ch     <= w_gnt_idx;
                        awid_q    <= 4'(w_gnt_idx);
                        awaddr_q  <= burst_addr(w_gnt_idx,
                                                |(w_gnt & ch_sync) ? '0 : wr_ptr[w_gnt_idx]);
                        awvalid_q <= 1'b1;
                        w_state   <= W_ADDR;
                    end else begin
                        w_state   <= W_IDLE;
                    end
                end
                W_ADDR: begin
                    if (m_axi.M_AXI_AWREADY) begin
                        awvalid_q <= 1'b0;
                        w_state   <= W_DATA;
                    end
                end
                W_DATA: if (m_axi.M_AXI_WREADY && m_axi.M_AXI_WLAST) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            r_state   <= R_IDLE;
            rd_ch     <= '0;
            arvalid_q <= 1'b0;
            arid_q    <= '0;
            araddr_q  <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (DDR_INIT_DONE) r_state <= R_ARB;
                R_ARB: begin
                    if (r_any) begin
                        rd_ch     <= r_gnt_idx;
                        arid_q    <= 4'(r_gnt_idx);
                        araddr_q  <= burst_addr(r_gnt_idx,
                                                |(r_gnt & ch_sync) ? '0 : rd_ptr[r_gnt_idx]);
                        arvalid_q <= 1'b1;
                        r_state   <= R_ADDR;
                    end else begin
                        r_state   <= R_IDLE;
                    end
                end
                R_ADDR: begin
                    if (m_axi.M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        r_state   <= R_DATA;
                    end
                end
                R_DATA: if (m_axi.M_AXI_RVALID && m_axi.M_AXI_RLAST) r_state <= R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Ring pointers: a sync against an in-flight burst is parked until that burst ends,
    // and a sync always beats a wrap (pointer to 0, no done pulse, frame not marked).
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            for (int c = 0; c < CH_NUM; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
            wr_pend      <= '0;
            rd_pend      <= '0;
            frame_valid  <= '0;
            wr_fram_done <= '0;
            rd_fram_done <= '0;
        end else begin
            wr_fram_done <= '0;
            rd_fram_done <= '0;
            for (int c = 0; c < CH_NUM; c++) begin
                if (w_end[c]) begin
                    wr_pend[c] <= 1'b0;
                    if (wr_pend[c] || ch_sync[c]) begin
                        wr_ptr[c] <= '0;
                    end else if (wr_ptr[c] == PTR_LAST) begin
                        wr_ptr[c]       <= '0;
                        wr_fram_done[c] <= 1'b1;
                        frame_valid[c]  <= 1'b1;
                    end else begin
                        wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
                    end
                end else if (ch_sync[c]) begin
                    if (w_busy[c]) wr_pend[c] <= 1'b1;
                    else           wr_ptr[c]  <= '0;
                end

                if (r_end[c]) begin
                    rd_pend[c] <= 1'b0;
                    if (rd_pend[c] || ch_sync[c]) begin
                        rd_ptr[c] <= '0;
                    end else if (rd_ptr[c] == PTR_LAST) begin
                        rd_ptr[c]       <= '0;
                        rd_fram_done[c] <= 1'b1;
                    end else begin
                        rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
                    end
                end else if (ch_sync[c]) begin
                    if (r_busy[c]) rd_pend[c] <= 1'b1;
                    else           rd_ptr[c]  <= '0;
                end
            end
        end
    end

endmodule
